// File: rtl/usb_reset_seq_if.sv
// Handshake bundle between a reset consumer (master) and the usb_reset_seq sequencer (slave).
// The master drives per-channel requests, and the sequencer returns the reset and status outputs.
interface usb_reset_seq_if #(
  parameter int NUM_CH = 3
);
  logic [NUM_CH-1:0] req_i;
  logic [NUM_CH-1:0] rst_o;
  logic              done_o;
  logic              busy_o;

  modport master (
    output req_i,
    input  rst_o,
    input  done_o,
    input  busy_o
  );

  modport slave (
    input  req_i,
    output rst_o,
    output done_o,
    output busy_o
  );
endinterface

// File: rtl/usb_reset_seq.sv
// Multi-channel reset sequencer: releases NUM_CH resets in ascending order after a quiet hold
// time, with a fixed gap between later releases; requests re-assert and restart from the lowest channel.
module usb_reset_seq #(
  parameter int NUM_CH      = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4
) (
  input logic            clk_i,
  input logic            rst_i,
  usb_reset_seq_if.slave bus
);

  localparam int CH_W  = $clog2(NUM_CH + 1);
  localparam int MAX_C = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [1:0] ST_HOLD = 2'd0;
  localparam logic [1:0] ST_GAP  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  if (NUM_CH < 2 || HOLD_CYCLES < 1 || GAP_CYCLES < 1) begin : g_param_check
    $fatal(1, "usb_reset_seq: NUM_CH must be >= 2, HOLD_CYCLES and GAP_CYCLES >= 1");
  end

  logic [1:0]        state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0] rst_q, rst_d;
  logic              done_q, done_d;
  logic              req_any_s;
  logic [CH_W-1:0]   req_min_s;

  // Lowest requested channel; NUM_CH when nothing is requested.
  always_comb begin
    req_min_s = CH_W'(NUM_CH);
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (bus.req_i[k]) begin
        req_min_s = CH_W'(k);
      end else begin
        req_min_s = req_min_s;
      end
    end
    req_any_s = |bus.req_i;
  end

  // Next-state logic; a request overrides any release due in the same cycle.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    if (req_any_s) begin
      ch_d    = (req_min_s < ch_q) ? req_min_s : ch_q;
      cnt_d   = '0;
      state_d = ST_HOLD;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
            ch_d    = ch_q + CH_W'(1);
            cnt_d   = '0;
            state_d = (ch_q == CH_W'(NUM_CH - 1)) ? ST_DONE : ST_GAP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
            ch_d    = ch_q + CH_W'(1);
            cnt_d   = '0;
            state_d = (ch_q == CH_W'(NUM_CH - 1)) ? ST_DONE : ST_GAP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          ch_d  = CH_W'(NUM_CH);
          cnt_d = '0;
        end
        default: begin
          state_d = ST_HOLD;
          ch_d    = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output image: every channel at or above the next-to-release index stays in reset.
  always_comb begin
    rst_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      rst_d[k] = (CH_W'(k) >= ch_d);
    end
    done_d = (state_d == ST_DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_HOLD;
      ch_q    <= '0;
      cnt_q   <= '0;
      rst_q   <= '1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
    end
  end

  assign bus.rst_o  = rst_q;
  assign bus.done_o = done_q;
  assign bus.busy_o = ~done_q;

endmodule

// File: tb/tb_usb_reset_seq.sv
// Self-checking bench for usb_reset_seq: directed plan scenarios plus random stimulus,
// all compared against a closed-form release-schedule model.
module tb_usb_reset_seq;

  localparam int NCH  = 3;
  localparam int HOLD = 16;
  localparam int GAP  = 4;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   n = 0;
  int   origin = 0;
  int   base = 0;
  int   t0 = 0;

  usb_reset_seq_if #(.NUM_CH(NCH)) bus ();

  usb_reset_seq #(.NUM_CH(NCH), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Schedule model: from cycle t0, channel k >= base is low from t0 + HOLD + (k-base)*GAP.
  function automatic logic [2:0] model_rst(int cyc);
    logic [2:0] v;
    v = 3'b000;
    for (int k = 0; k < NCH; k++) begin
      if (k >= base && (cyc - t0) < HOLD + (k - base) * GAP) v[k] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [4:0] model_out(int cyc);
    logic [2:0] r;
    r = model_rst(cyc);
    return {r, r == 3'b000, r != 3'b000};
  endfunction

  function automatic int lowest_one(logic [2:0] v);
    for (int k = 0; k < NCH; k++) if (v[k]) return k;
    return NCH;
  endfunction

  task automatic tick(input logic r, input logic [2:0] q);
    int cur;
    int m;
    rst_i = r;
    bus.req_i = q;
    @(posedge clk);
    #1;
    if (r) begin
      base = 0;
      t0 = n + 1;
    end else if (q != 3'b000) begin
      cur = lowest_one(model_rst(n));
      m = lowest_one(q);
      base = (m < cur) ? m : cur;
      t0 = n + 1;
    end
    n++;
  endtask

  task automatic reset_dut();
    for (int i = 0; i < 5; i++) tick(1'b1, 3'b000);
    origin = n;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 3'($urandom_range(0, 7)));
      total++;
      if (bus.rst_o !== 3'b111 || bus.done_o !== 1'b0 || bus.busy_o !== 1'b1) begin
        bad++;
        $display("FAIL reset i=%0d rst_o=%b done_o=%b busy_o=%b expected 111/0/1", i, bus.rst_o, bus.done_o, bus.busy_o);
      end
    end
    origin = n;
  endtask

  task automatic test_power_on_and_req();
    int pc[8] = '{0, 15, 16, 20, 24, 31, 47, 51};
    logic [2:0] pv[8] = '{3'b111, 3'b111, 3'b110, 3'b100, 3'b000, 3'b110, 3'b100, 3'b000};
    reset_dut();
    for (int c = 0; c < 56; c++) begin
      for (int j = 0; j < 8; j++) begin
        if (n - origin == pc[j]) begin
          total++;
          if (bus.rst_o !== pv[j] || bus.done_o !== (pv[j] == 3'b000) || bus.busy_o !== (pv[j] != 3'b000)) begin
            bad++;
            $display("FAIL power_on_req cyc=%0d rst_o=%b done_o=%b busy_o=%b expected rst_o=%b", n - origin, bus.rst_o, bus.done_o, bus.busy_o, pv[j]);
          end
        end
      end
      total++;
      if ({bus.rst_o, bus.done_o, bus.busy_o} !== model_out(n)) begin
        bad++;
        $display("FAIL power_on_req_model cyc=%0d got=%b expected=%b", n - origin, {bus.rst_o, bus.done_o, bus.busy_o}, model_out(n));
      end
      tick(1'b0, (c == 30) ? 3'b010 : 3'b000);
    end
  endtask

  task automatic test_mid_seq();
    int pc[4] = '{19, 35, 39, 43};
    logic [2:0] pv[4] = '{3'b111, 3'b110, 3'b100, 3'b000};
    reset_dut();
    for (int c = 0; c < 46; c++) begin
      tick(1'b0, (c == 18) ? 3'b001 : 3'b000);
      for (int j = 0; j < 4; j++) begin
        if (n - origin == pc[j]) begin
          total++;
          if (bus.rst_o !== pv[j] || bus.done_o !== (pv[j] == 3'b000)) begin
            bad++;
            $display("FAIL mid_seq cyc=%0d rst_o=%b done_o=%b expected rst_o=%b", n - origin, bus.rst_o, bus.done_o, pv[j]);
          end
        end
      end
    end
  endtask

  task automatic test_held_req();
    int pc[4] = '{31, 40, 55, 56};
    logic [2:0] pv[4] = '{3'b100, 3'b100, 3'b100, 3'b000};
    reset_dut();
    for (int c = 0; c < 58; c++) begin
      tick(1'b0, (c >= 30 && c <= 39) ? 3'b100 : 3'b000);
      for (int j = 0; j < 4; j++) begin
        if (n - origin == pc[j]) begin
          total++;
          if (bus.rst_o !== pv[j] || bus.done_o !== (pv[j] == 3'b000)) begin
            bad++;
            $display("FAIL held_req cyc=%0d rst_o=%b done_o=%b expected rst_o=%b", n - origin, bus.rst_o, bus.done_o, pv[j]);
          end
        end
      end
    end
  endtask

  task automatic test_collision();
    int pc[4] = '{16, 32, 36, 40};
    logic [2:0] pv[4] = '{3'b111, 3'b110, 3'b100, 3'b000};
    reset_dut();
    for (int c = 0; c < 42; c++) begin
      tick(1'b0, (c == 15) ? 3'b100 : 3'b000);
      for (int j = 0; j < 4; j++) begin
        if (n - origin == pc[j]) begin
          total++;
          if (bus.rst_o !== pv[j] || bus.done_o !== (pv[j] == 3'b000)) begin
            bad++;
            $display("FAIL collision cyc=%0d rst_o=%b done_o=%b expected rst_o=%b", n - origin, bus.rst_o, bus.done_o, pv[j]);
          end
        end
      end
    end
  endtask

  task automatic test_rst_mid();
    int pc[5] = '{21, 22, 38, 42, 46};
    logic [2:0] pv[5] = '{3'b100, 3'b111, 3'b110, 3'b100, 3'b000};
    reset_dut();
    for (int c = 0; c < 48; c++) begin
      tick(c == 21, (c == 21) ? 3'b111 : 3'b000);
      for (int j = 0; j < 5; j++) begin
        if (n - origin == pc[j]) begin
          total++;
          if (bus.rst_o !== pv[j] || bus.done_o !== (pv[j] == 3'b000) || bus.busy_o !== (pv[j] != 3'b000)) begin
            bad++;
            $display("FAIL rst_mid cyc=%0d rst_o=%b done_o=%b busy_o=%b expected rst_o=%b", n - origin, bus.rst_o, bus.done_o, bus.busy_o, pv[j]);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    logic       r;
    logic [2:0] q;
    reset_dut();
    for (int c = 0; c < 800; c++) begin
      r = ($urandom_range(0, 59) == 0);
      q = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      tick(r, q);
      total++;
      if ({bus.rst_o, bus.done_o, bus.busy_o} !== model_out(n)) begin
        bad++;
        $display("FAIL random cyc=%0d got=%b expected=%b", c, {bus.rst_o, bus.done_o, bus.busy_o}, model_out(n));
      end
    end
  endtask

  initial begin
    bus.req_i = 3'b000;
    test_reset();
    test_power_on_and_req();
    test_mid_seq();
    test_held_req();
    test_collision();
    test_rst_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
